// File: rtl/oc8051_wb_mem_arbiter_if.sv
// Bus bundle for the oc8051 wbi/wbd to shared-memory arbiter.
// slave: arbiter view; master: CPU and memory view.
interface oc8051_wb_mem_arbiter_if #(
  parameter int AW = 16
);
  logic [AW-1:0] wbi_adr_i;
  logic          wbi_stb_i;
  logic          wbi_cyc_i;
  logic [31:0]   wbi_dat_o;
  logic          wbi_ack_o;
  logic          wbi_err_o;

  logic [AW-1:0] wbd_adr_i;
  logic [7:0]    wbd_dat_i;
  logic          wbd_we_i;
  logic          wbd_stb_i;
  logic          wbd_cyc_i;
  logic [7:0]    wbd_dat_o;
  logic          wbd_ack_o;
  logic          wbd_err_o;

  logic [AW-1:0] mem_adr_o;
  logic [7:0]    mem_dat_o;
  logic          mem_we_o;
  logic          mem_stb_o;
  logic          mem_cyc_o;
  logic [7:0]    mem_dat_i;
  logic          mem_ack_i;

  modport slave (
    input  wbi_adr_i, wbi_stb_i, wbi_cyc_i,
    output wbi_dat_o, wbi_ack_o, wbi_err_o,
    input  wbd_adr_i, wbd_dat_i, wbd_we_i,
    input  wbd_stb_i, wbd_cyc_i,
    output wbd_dat_o, wbd_ack_o, wbd_err_o,
    output mem_adr_o, mem_dat_o, mem_we_o,
    output mem_stb_o, mem_cyc_o,
    input  mem_dat_i, mem_ack_i
  );

  modport master (
    output wbi_adr_i, wbi_stb_i, wbi_cyc_i,
    input  wbi_dat_o, wbi_ack_o, wbi_err_o,
    output wbd_adr_i, wbd_dat_i, wbd_we_i,
    output wbd_stb_i, wbd_cyc_i,
    input  wbd_dat_o, wbd_ack_o, wbd_err_o,
    input  mem_adr_o, mem_dat_o, mem_we_o,
    input  mem_stb_o, mem_cyc_o,
    output mem_dat_i, mem_ack_i
  );
endinterface

// File: rtl/oc8051_wb_mem_arbiter.sv
// Round-robin arbiter: 32-bit wbi fetch (4 byte reads) and 8-bit wbd onto one memory.
// Optional ack timeout with err pulse: define OC8051_WB_ARB_TIMEOUT_EN.
module oc8051_wb_mem_arbiter #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  oc8051_wb_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    IFETCH,
    DONE
  } state_t;

  state_t        state;
  logic          last_i;
  logic [1:0]    cnt;
  logic          drop;
  logic [23:0]   word_lo;
  logic [AW-1:0] adr;
  logic [7:0]    wdat;
  logic          we;
  logic          stb;
  logic [31:0]   idat;
  logic          iack;
  logic [7:0]    ddat;
  logic          dack;

  logic ireq;
  logic dreq;
  logic mack;
  logic pick_i;

  assign ireq   = bus.wbi_stb_i & bus.wbi_cyc_i;
  assign dreq   = bus.wbd_stb_i & bus.wbd_cyc_i;
  assign mack   = bus.mem_ack_i & stb;
  // tie goes to the port that did not win last time
  assign pick_i = ireq & (~dreq | ~last_i);

`ifdef OC8051_WB_ARB_TIMEOUT_EN
  logic        ierr;
  logic        derr;
  logic        tmo;
  logic [15:0] wait_cnt;

  assign tmo = stb & ~mack &
               (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !stb || mack)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_i  <= 1'b0;
      cnt     <= '0;
      drop    <= 1'b0;
      word_lo <= '0;
      adr     <= '0;
      wdat    <= '0;
      we      <= 1'b0;
      stb     <= 1'b0;
      idat    <= '0;
      iack    <= 1'b0;
      ddat    <= '0;
      dack    <= 1'b0;
`ifdef OC8051_WB_ARB_TIMEOUT_EN
      ierr    <= 1'b0;
      derr    <= 1'b0;
`endif
    end else begin
      iack <= 1'b0;
      dack <= 1'b0;
`ifdef OC8051_WB_ARB_TIMEOUT_EN
      ierr <= 1'b0;
      derr <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (ireq | dreq) begin
            stb    <= 1'b1;
            cnt    <= '0;
            drop   <= 1'b0;
            last_i <= pick_i;
            if (pick_i) begin
              state <= IFETCH;
              adr   <= bus.wbi_adr_i;
              we    <= 1'b0;
              wdat  <= '0;
            end else begin
              state <= DATA;
              adr   <= bus.wbd_adr_i;
              we    <= bus.wbd_we_i;
              wdat  <= bus.wbd_dat_i;
            end
          end
        end
        DATA: begin
          if (!dreq)
            drop <= 1'b1;
          if (mack) begin
            stb <= 1'b0;
            we  <= 1'b0;
            if (drop | ~dreq) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              dack  <= 1'b1;
              ddat  <= we ? 8'h00 : bus.mem_dat_i;
            end
          end
`ifdef OC8051_WB_ARB_TIMEOUT_EN
          else if (tmo) begin
            stb <= 1'b0;
            we  <= 1'b0;
            if (drop | ~dreq) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              derr  <= 1'b1;
              ddat  <= 8'h00;
            end
          end
`endif
        end
        IFETCH: begin
          if (!ireq)
            drop <= 1'b1;
          if (mack) begin
            unique case (cnt)
              2'd0: word_lo[7:0]   <= bus.mem_dat_i;
              2'd1: word_lo[15:8]  <= bus.mem_dat_i;
              2'd2: word_lo[23:16] <= bus.mem_dat_i;
              2'd3: ;
            endcase
            cnt <= cnt + 2'd1;
            // an abandoned fetch stops after the byte in flight
            if (drop | ~ireq) begin
              stb   <= 1'b0;
              state <= IDLE;
            end else if (cnt == 2'd3) begin
              stb   <= 1'b0;
              state <= DONE;
              iack  <= 1'b1;
              idat  <= {bus.mem_dat_i, word_lo};
            end else begin
              adr <= adr + AW'(1);
            end
          end
`ifdef OC8051_WB_ARB_TIMEOUT_EN
          else if (tmo) begin
            stb <= 1'b0;
            if (drop | ~ireq) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              ierr  <= 1'b1;
              idat  <= '0;
            end
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wbi_dat_o = idat;
  assign bus.wbi_ack_o = iack;
  assign bus.wbd_dat_o = ddat;
  assign bus.wbd_ack_o = dack;
  assign bus.mem_adr_o = adr;
  assign bus.mem_dat_o = wdat;
  assign bus.mem_we_o  = we;
  assign bus.mem_stb_o = stb;
  assign bus.mem_cyc_o = stb;

`ifdef OC8051_WB_ARB_TIMEOUT_EN
  assign bus.wbi_err_o = ierr;
  assign bus.wbd_err_o = derr;
`else
  assign bus.wbi_err_o = 1'b0;
  assign bus.wbd_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_oc8051_wb_mem_arbiter.sv
// Directed bench for oc8051_wb_mem_arbiter with a byte memory responder.
// Timeout scenario is built when OC8051_WB_ARB_TIMEOUT_EN is defined.
module tb_oc8051_wb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oc8051_wb_mem_arbiter_if #(.AW(16)) bus();

  oc8051_wb_mem_arbiter #(
    .AW(16),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] mem_img [256];
  bit ack_en = 1'b1;
  logic [15:0] adr_q[$];
  logic [7:0] ord_q[$];
  int iack_n = 0;
  int dack_n = 0;
  int ierr_n = 0;
  int derr_n = 0;
  int stb_n = 0;
  int cyc = 0;
  int mack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // byte memory: acks every cycle while strobed (unless ack_en=0)
  always @(negedge clk) begin
    bus.mem_ack_i = ack_en & bus.mem_stb_o;
    bus.mem_dat_i = mem_img[bus.mem_adr_o[7:0]];
    if (bus.mem_ack_i === 1'b1) begin
      adr_q.push_back(bus.mem_adr_o);
      mack_cyc = cyc;
      if (bus.mem_we_o)
        mem_img[bus.mem_adr_o[7:0]] = bus.mem_dat_o;
    end
    if (bus.mem_stb_o === 1'b1) stb_n++;
    if (bus.wbi_ack_o === 1'b1) begin
      iack_n++;
      ord_q.push_back("I");
    end
    if (bus.wbd_ack_o === 1'b1) begin
      dack_n++;
      ord_q.push_back("D");
    end
    if (bus.wbi_err_o === 1'b1) ierr_n++;
    if (bus.wbd_err_o === 1'b1) derr_n++;
  end

  task automatic idle_reqs();
    bus.wbi_adr_i = '0;
    bus.wbi_stb_i = 1'b0;
    bus.wbi_cyc_i = 1'b0;
    bus.wbd_adr_i = '0;
    bus.wbd_dat_i = '0;
    bus.wbd_we_i  = 1'b0;
    bus.wbd_stb_i = 1'b0;
    bus.wbd_cyc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_reqs();
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.mem_stb_o, bus.mem_cyc_o, bus.mem_we_o,
         bus.wbi_ack_o, bus.wbd_ack_o,
         bus.wbi_err_o, bus.wbd_err_o} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 0000000",
        {bus.mem_stb_o, bus.mem_cyc_o, bus.mem_we_o,
         bus.wbi_ack_o, bus.wbd_ack_o,
         bus.wbi_err_o, bus.wbd_err_o});
    end
    tests++;
    if (bus.mem_adr_o !== 16'h0 || bus.mem_dat_o !== 8'h0) begin
      fails++;
      $display("FAIL reset_mem: adr %h dat %h want 0",
        bus.mem_adr_o, bus.mem_dat_o);
    end
    tests++;
    if (bus.wbi_dat_o !== 32'h0 || bus.wbd_dat_o !== 8'h0) begin
      fails++;
      $display("FAIL reset_dat: wbi %h wbd %h want 0",
        bus.wbi_dat_o, bus.wbd_dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch(input logic [15:0] base,
                            input logic [31:0] exp);
    int i0;
    int d0;
    int ac;
    bit got;
    bit bad;
    logic [15:0] ea;
    i0 = iack_n;
    d0 = dack_n;
    ac = 0;
    got = 1'b0;
    bad = 1'b0;
    adr_q.delete();
    bus.wbi_adr_i = base;
    bus.wbi_stb_i = 1'b1;
    bus.wbi_cyc_i = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.wbi_ack_o === 1'b1) begin
        got = 1'b1;
        ac = cyc;
      end
    end
    bus.wbi_stb_i = 1'b0;
    bus.wbi_cyc_i = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL fetch_wait %h: no wbi_ack_o, want one", base);
    end
    tests++;
    if (bus.wbi_dat_o !== exp) begin
      fails++;
      $display("FAIL fetch_word %h: got %h want %h",
        base, bus.wbi_dat_o, exp);
    end
    tests++;
    if (adr_q.size() != 4) begin
      bad = 1'b1;
    end else begin
      for (int j = 0; j < 4; j++) begin
        ea = base + 16'(j);
        if (adr_q[j] !== ea) bad = 1'b1;
      end
    end
    if (bad) begin
      fails++;
      $display("FAIL fetch_adr %h: got %p want base..base+3",
        base, adr_q);
    end
    tests++;
    if (ac != mack_cyc + 1) begin
      fails++;
      $display("FAIL fetch_lat %h: ack cyc %0d want %0d",
        base, ac, mack_cyc + 1);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (iack_n - i0 != 1 || dack_n != d0) begin
      fails++;
      $display("FAIL fetch_pulses %h: iack %0d dack %0d want 1 0",
        base, iack_n - i0, dack_n - d0);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    idle_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ord_q.delete();
    bus.wbi_adr_i = 16'h0010;
    bus.wbd_adr_i = 16'h0005;
    bus.wbd_we_i  = 1'b0;
    bus.wbi_stb_i = 1'b1;
    bus.wbi_cyc_i = 1'b1;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_cyc_i = 1'b1;
    for (int k = 0; k < 200 && ord_q.size() < 4; k++)
      @(negedge clk);
    idle_reqs();
    tests++;
    if (ord_q.size() < 4 || ord_q[0] !== "I" ||
        ord_q[1] !== "D" || ord_q[2] !== "I" ||
        ord_q[3] !== "D") begin
      fails++;
      $display("FAIL rr_order: got %p want I D I D", ord_q);
    end
    tests++;
    if (bus.wbi_dat_o !== 32'h44332211) begin
      fails++;
      $display("FAIL rr_word: got %h want 44332211", bus.wbi_dat_o);
    end
    tests++;
    if (bus.wbd_dat_o !== 8'h22) begin
      fails++;
      $display("FAIL rr_rdata: got %h want 22", bus.wbd_dat_o);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    bit got;
    bit seen;
    int ac;
    logic [15:0] sadr;
    logic [7:0] sdat;
    logic swe;
    got = 1'b0;
    seen = 1'b0;
    ac = 0;
    sadr = '0;
    sdat = '0;
    swe = 1'b0;
    bus.wbd_adr_i = 16'h0020;
    bus.wbd_dat_i = 8'hA5;
    bus.wbd_we_i  = 1'b1;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_cyc_i = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_stb_o === 1'b1 && !seen) begin
        seen = 1'b1;
        sadr = bus.mem_adr_o;
        sdat = bus.mem_dat_o;
        swe = bus.mem_we_o;
      end
      if (bus.wbd_ack_o === 1'b1) begin
        got = 1'b1;
        ac = cyc;
      end
    end
    idle_reqs();
    tests++;
    if (!got || !seen) begin
      fails++;
      $display("FAIL wr_wait: ack %0d stb %0d want 1 1", got, seen);
    end
    tests++;
    if (swe !== 1'b1 || sadr !== 16'h0020 || sdat !== 8'hA5) begin
      fails++;
      $display("FAIL wr_bus: we %b adr %h dat %h want 1 0020 a5",
        swe, sadr, sdat);
    end
    tests++;
    if (ac != mack_cyc + 1) begin
      fails++;
      $display("FAIL wr_lat: ack cyc %0d want %0d", ac, mack_cyc + 1);
    end
    tests++;
    if (bus.wbd_dat_o !== 8'h00 || mem_img[8'h20] !== 8'hA5) begin
      fails++;
      $display("FAIL wr_result: wbd_dat %h mem %h want 00 a5",
        bus.wbd_dat_o, mem_img[8'h20]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch();
    int i0;
    bit got;
    i0 = iack_n;
    got = 1'b0;
    adr_q.delete();
    bus.wbi_adr_i = 16'h0100;
    bus.wbi_stb_i = 1'b1;
    bus.wbi_cyc_i = 1'b1;
    for (int k = 0; k < 30 && adr_q.size() < 2; k++)
      @(negedge clk);
    rst_n = 1'b0;
    idle_reqs();
    @(negedge clk);
    tests++;
    if ({bus.mem_stb_o, bus.mem_cyc_o, bus.wbi_ack_o} !== 3'b0 ||
        bus.mem_adr_o !== 16'h0 || bus.wbi_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL midrst_out: stb %b adr %h wdat %h want 0",
        bus.mem_stb_o, bus.mem_adr_o, bus.wbi_dat_o);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (iack_n != i0) begin
      fails++;
      $display("FAIL midrst_noack: iack %0d want 0", iack_n - i0);
    end
    bus.wbd_adr_i = 16'h0003;
    bus.wbd_we_i  = 1'b0;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_cyc_i = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.wbd_ack_o === 1'b1) got = 1'b1;
    end
    idle_reqs();
    tests++;
    if (!got || bus.wbd_dat_o !== 8'h44) begin
      fails++;
      $display("FAIL midrst_data: ack %0d dat %h want 1 44",
        got, bus.wbd_dat_o);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef OC8051_WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int e0;
    int d0;
    bit got;
    e0 = derr_n;
    d0 = dack_n;
    got = 1'b0;
    ack_en = 1'b0;
    stb_n = 0;
    bus.wbd_adr_i = 16'h0030;
    bus.wbd_we_i  = 1'b0;
    bus.wbd_stb_i = 1'b1;
    bus.wbd_cyc_i = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.wbd_err_o === 1'b1) got = 1'b1;
    end
    idle_reqs();
    repeat (3) @(negedge clk);
    ack_en = 1'b1;
    tests++;
    if (!got || stb_n != 4) begin
      fails++;
      $display("FAIL tmo_stb: err %0d stb cycles %0d want 1 4",
        got, stb_n);
    end
    tests++;
    if (derr_n - e0 != 1 || bus.wbd_dat_o !== 8'h00) begin
      fails++;
      $display("FAIL tmo_err: pulses %0d dat %h want 1 00",
        derr_n - e0, bus.wbd_dat_o);
    end
    tests++;
    if (dack_n != d0 || ierr_n != 0) begin
      fails++;
      $display("FAIL tmo_other: dack %0d ierr %0d want 0 0",
        dack_n - d0, ierr_n);
    end
  endtask
`else
  task automatic test_no_err();
    tests++;
    if (ierr_n != 0 || derr_n != 0) begin
      fails++;
      $display("FAIL no_err: ierr %0d derr %0d want 0 0",
        ierr_n, derr_n);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem_img[i] = 8'((i % 4 + 1) * 17);
    idle_reqs();
    test_reset();
    test_fetch(16'h0100, 32'h44332211);
    test_round_robin();
    test_write();
    test_fetch(16'hFFFE, 32'h22114433);
    test_reset_mid_fetch();
`ifdef OC8051_WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oc8051_wb_mem_arbiter.md
Name: oc8051_wb_mem_arbiter

Overview:
- Shares one 8-bit memory slave between the oc8051 instruction Wishbone port and data Wishbone port.
  - Instruction port: 32-bit, read-only.
  - Data port: 8-bit, read/write.
- Each instruction fetch is split into four sequential byte reads, assembled little-endian.
- Arbitration between the two ports is round-robin.
- Sits between oc8051_fv_top's wbi/wbd buses and the shared boot/program memory.

Parameters:
AW, 16, address width of all three buses
TIMEOUT, 255, max cycles waiting for mem_ack_i per byte before abort (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
wbi_adr_i  input  AW  instruction fetch base address
wbi_stb_i  input  1  instruction strobe
wbi_cyc_i  input  1  instruction cycle
wbi_dat_o  output  32  fetched word, {b3,b2,b1,b0}, b0 from base address
wbi_ack_o  output  1  instruction ack, 1-cycle pulse
wbi_err_o  output  1  instruction error, 1-cycle pulse
wbd_adr_i  input  AW  data address
wbd_dat_i  input  8  data write value
wbd_we_i  input  1  data write enable
wbd_stb_i  input  1  data strobe
wbd_cyc_i  input  1  data cycle
wbd_dat_o  output  8  data read value
wbd_ack_o  output  1  data ack, 1-cycle pulse
wbd_err_o  output  1  data error, 1-cycle pulse
mem_adr_o  output  AW  shared memory address
mem_dat_o  output  8  shared memory write data
mem_we_o  output  1  shared memory write enable
mem_stb_o  output  1  shared memory strobe
mem_cyc_o  output  1  shared memory cycle, equal to mem_stb_o
mem_dat_i  input  8  shared memory read data
mem_ack_i  input  1  shared memory ack

Behaviour:
- A port requests when its stb && cyc is high. All outputs are registered.
- Reset (rst_n=0 at posedge, any state, including mid-fetch):
  - state=IDLE, all outputs 0, byte counter 0, last_grant=DATA.
  - Any in-flight transaction is dropped with no ack.
- States: IDLE, DATA, IFETCH, DONE.
- IDLE:
  - Only one port requesting: grant it.
  - Both requesting: grant the port opposite last_grant. After reset the instruction port wins the first tie.
  - On grant: next cycle mem_stb_o=1 with the address latched, and last_grant is updated.
- DATA:
  - mem_adr_o=wbd_adr_i latched, mem_we_o=wbd_we_i, mem_dat_o=wbd_dat_i.
  - On mem_ack_i at cycle M: mem_stb_o=0 at M+1, wbd_ack_o=1 at M+1, wbd_dat_o=mem_dat_i (read) or 0 (write). Go to DONE.
- IFETCH:
  - Counter cnt 0..3; mem_adr_o = base+cnt mod 2^AW, so 0xFFFE fetches FFFE, FFFF, 0000, 0001.
  - mem_we_o=0; mem_stb_o held high across all four bytes.
  - Each mem_ack_i captures mem_dat_i into byte cnt, increments cnt and updates the address next cycle.
  - Fourth ack at cycle M: mem_stb_o=0 at M+1, wbi_ack_o=1 at M+1 with the full word. Go to DONE.
- DONE:
  - Acks are low; one idle cycle follows so the master can drop stb. Requests are sampled again in IDLE at M+2.
  - Back-to-back requests from one master therefore cost at least 3 cycles of overhead.
- Master drops stb/cyc while granted: the current byte or fetch completes on the memory side, the result is discarded, no ack is issued, and the block returns to IDLE.
- Ack and err are never both high, and never asserted on the non-granted port.
- mem_ack_i while mem_stb_o=0 is ignored.
- wbi_dat_o and wbd_dat_o hold their last value except when updated on ack or zeroed on err.

Optional Feature:
OC8051_WB_ARB_TIMEOUT_EN
- Defined:
  - A wait counter resets on every mem_ack_i and on grant.
  - If it reaches TIMEOUT with no ack: mem_stb_o=0 next cycle, the granted port's err_o pulses 1 cycle, its dat_o=0, then DONE.
  - A partial fetch is discarded.
- Undefined: the block waits forever for mem_ack_i, and wbi_err_o/wbd_err_o are constant 0.

Test Plan:
- Reset, then wbi request at 0x0100, memory acks every cycle with bytes 11,22,33,44 -> addresses 0100..0103 issued; wbi_ack_o pulses once with wbi_dat_o=0x44332211; wbd_ack_o stays 0.
- wbi and wbd requesting in the same cycle after reset -> instruction fetch served first, then data; with both held requesting, the order alternates I,D,I,D.
- wbd write 0xA5 to 0x0020 -> mem_we_o=1, mem_adr_o=0x0020, mem_dat_o=0xA5; wbd_ack_o one cycle after mem_ack_i.
- Fetch at 0xFFFE -> mem addresses FFFE, FFFF, 0000, 0001.
- rst_n=0 after the second byte of a fetch -> next cycle all outputs 0, no wbi_ack_o; a following data request is granted, since last_grant=DATA resets only tie-breaking.
- With OC8051_WB_ARB_TIMEOUT_EN, TIMEOUT=4, memory never acks a wbd read -> mem_stb_o drops after 4 waiting cycles; wbd_err_o pulses once with wbd_dat_o=0; wbd_ack_o stays 0.
